// File: rtl/pll_div_bank.sv
// Bank of programmable clock dividers with phase alignment and a lock indicator.
// Optional feature: define PLL_DIV_BANK_READBACK_EN to enable register readback on DO.
`timescale 1ns/1ps
module pll_div_bank #(
   parameter int unsigned NUM_OUT     = 6,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned LOCK_CYCLES = 64
) (
   input  logic               clk,
   input  logic               RST_N,
   input  logic               PWRDWN,
   input  logic [6:0]         DADDR,
   input  logic               DEN,
   input  logic               DWE,
   input  logic [15:0]        DI,
   output logic [15:0]        DO,
   output logic               DRDY,
   output logic [NUM_OUT-1:0] CLKOUT,
   output logic               LOCKED
);

   localparam int unsigned LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   typedef enum logic [1:0] {STOP, ALIGN, LOCK} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   sh_div  [NUM_OUT];
   logic [CNT_W-1:0]   sh_high [NUM_OUT];
   logic [CNT_W-1:0]   sh_ph   [NUM_OUT];
   logic [CNT_W-1:0]   act_div [NUM_OUT];
   logic [CNT_W-1:0]   act_high[NUM_OUT];
   logic [CNT_W-1:0]   act_ph  [NUM_OUT];
   logic [CNT_W-1:0]   cnt     [NUM_OUT];
   logic [LCK_W-1:0]   lock_cnt;
   logic [NUM_OUT-1:0] clkout_r;
   logic               locked_r;
   logic               drdy_r;
   logic               apply_pend;

   logic [4:0]         ch_c;
   logic [1:0]         fld_c;
   logic [CNT_W-1:0]   wd_c;
   logic               ch_ok_c;
   logic               wr_c;
   logic               apply_c;
   logic               enter_align_c;
   logic               lock_done_c;
   logic               di_unused;

   // Start offset so the first rise lands PHASE cycles after a phase-0 channel.
   function automatic logic [CNT_W-1:0] preset_f(input logic [CNT_W-1:0] d,
                                                  input logic [CNT_W-1:0] p);
      logic [CNT_W-1:0] pe;
      pe = (p >= d) ? d - CNT_W'(1) : p;
      return (pe == '0) ? '0 : d - pe;
   endfunction

   function automatic logic [CNT_W-1:0] inc_f(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] d);
      logic [CNT_W:0] n;
      n = {1'b0, c} + (CNT_W+1)'(1);
      return (n >= {1'b0, d}) ? '0 : n[CNT_W-1:0];
   endfunction

   assign ch_c      = DADDR[6:2];
   assign fld_c     = DADDR[1:0];
   assign wd_c      = DI[CNT_W-1:0];
   assign di_unused = ^DI;
   assign ch_ok_c   = 32'(ch_c) < NUM_OUT;
   assign wr_c      = DEN & DWE & ch_ok_c;
   assign apply_c   = wr_c & (fld_c == 2'd3) & DI[0];

   // Shadow registers take clamped writes; APPLY snapshots them into the active set.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            sh_div[i]   <= CNT_W'(2);
            sh_high[i]  <= CNT_W'(1);
            sh_ph[i]    <= '0;
            act_div[i]  <= CNT_W'(2);
            act_high[i] <= CNT_W'(1);
            act_ph[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (wr_c && ch_c == 5'(i)) begin
               case (fld_c)
                  2'd0: sh_div[i] <= (wd_c < CNT_W'(2)) ? CNT_W'(2) : wd_c;
                  2'd1: sh_high[i] <= (wd_c == '0) ? CNT_W'(1) :
                                      (wd_c >= sh_div[i]) ? sh_div[i] - CNT_W'(1) : wd_c;
                  2'd2: sh_ph[i] <= (wd_c >= sh_div[i]) ? sh_div[i] - CNT_W'(1) : wd_c;
                  default: ;
               endcase
            end
            if (apply_c) begin
               act_div[i]  <= sh_div[i];
               act_high[i] <= sh_high[i];
               act_ph[i]   <= sh_ph[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) state <= ALIGN;
      else        state <= state_nxt;
   end

   // Power-down wins over everything; a pending APPLY restarts alignment.
   always_comb begin
      state_nxt     = state;
      enter_align_c = 1'b0;
      lock_done_c   = 1'b0;
      if (PWRDWN) begin
         state_nxt = STOP;
      end else if (apply_pend) begin
         state_nxt     = ALIGN;
         enter_align_c = 1'b1;
      end else begin
         case (state)
            STOP: begin
               state_nxt     = ALIGN;
               enter_align_c = 1'b1;
            end
            ALIGN: begin
               if (lock_cnt == LCK_W'(LOCK_CYCLES - 1)) begin
                  state_nxt   = LOCK;
                  lock_done_c = 1'b1;
               end
            end
            LOCK: ;
            default: begin
               state_nxt     = ALIGN;
               enter_align_c = 1'b1;
            end
         endcase
      end
   end

   // Divider counters, divided clocks and lock tracking.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
         lock_cnt   <= '0;
         clkout_r   <= '0;
         locked_r   <= 1'b0;
         apply_pend <= 1'b0;
      end else begin
         apply_pend <= apply_c;
         if (PWRDWN) begin
            clkout_r <= '0;
            locked_r <= 1'b0;
         end else if (enter_align_c) begin
            for (int i = 0; i < NUM_OUT; i++) cnt[i] <= preset_f(act_div[i], act_ph[i]);
            lock_cnt <= '0;
            clkout_r <= '0;
            locked_r <= 1'b0;
         end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
               clkout_r[i] <= (cnt[i] < act_high[i]);
               cnt[i]      <= inc_f(cnt[i], act_div[i]);
            end
            if (lock_done_c)          locked_r <= 1'b1;
            else if (state == ALIGN)  lock_cnt <= lock_cnt + LCK_W'(1);
            if (apply_c)              locked_r <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) drdy_r <= 1'b0;
      else        drdy_r <= DEN;
   end

`ifdef PLL_DIV_BANK_READBACK_EN
   logic [15:0] rd_c;
   logic [15:0] do_r;

   // Read mux over the shadow fields; out-of-range channels read as zero.
   always_comb begin
      rd_c = '0;
      if (DEN && !DWE && ch_ok_c) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (ch_c == 5'(i)) begin
               case (fld_c)
                  2'd0:    rd_c = 16'(sh_div[i]);
                  2'd1:    rd_c = 16'(sh_high[i]);
                  2'd2:    rd_c = 16'(sh_ph[i]);
                  default: rd_c = {15'b0, locked_r};
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) do_r <= '0;
      else        do_r <= rd_c;
   end

   assign DO = do_r;
`else
   assign DO = '0;
`endif

   assign DRDY   = drdy_r;
   assign CLKOUT = clkout_r;
   assign LOCKED = locked_r;

endmodule
